// File: rtl/s100_bus_pkg.sv
// Shared constants, FSM state type and decode helper for the S-100 bus controller.
package s100_bus_pkg;

  localparam int         STATUS_INP    = 6;
  localparam int         STATUS_OUT    = 4;
  localparam logic [7:0] OP_JMP        = 8'hC3;
  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } bus_state_e;

  // Masked compare used by both the memory-region and the I/O-port decoders.
  function automatic logic field_match(input logic [7:0] value,
                                       input logic [7:0] base,
                                       input logic [7:0] mask);
    return (value & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/s100_boot_seq.sv
// Turn-key boot overlay: serves a JMP BOOT_VECTOR over the first three completed reads.
module s100_boot_seq
  import s100_bus_pkg::*;
#(
  parameter int          BOOT_EN     = 1,
  parameter logic [15:0] BOOT_VECTOR = 16'hFD00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_done,
  output logic       boot_active,
  output logic [7:0] boot_byte
);

  logic [1:0] byte_cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt    <= 2'd0;
      boot_active <= (BOOT_EN != 0);
    end else if (boot_active && rd_done) begin
      if (byte_cnt == 2'd2) begin
        byte_cnt    <= 2'd0;
        boot_active <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    case (byte_cnt)
      2'd0:    boot_byte = OP_JMP;
      2'd1:    boot_byte = BOOT_VECTOR[7:0];
      default: boot_byte = BOOT_VECTOR[15:8];
    endcase
  end

endmodule

// File: rtl/s100_bus_ctrl.sv
// S-100 bus controller: status latch, region/port decode, wait states and boot overlay.
// Optional access-fault reporting is built when S100_BUS_FAULT_EN is defined.
module s100_bus_ctrl
  import s100_bus_pkg::*;
#(
  parameter int                NREG        = 4,
  parameter int                NIO         = 2,
  // Region 0 occupies the low byte of each packed table.
  parameter logic [8*NREG-1:0] REG_BASE    = {8'hFF, 8'hFD, 8'hFB, 8'h00},
  parameter logic [8*NREG-1:0] REG_MASK    = {8'hFF, 8'hFF, 8'hFF, 8'hE0},
  parameter logic [NREG-1:0]   REG_RO      = 4'b0100,
  parameter logic [2*NREG-1:0] REG_WAIT    = 8'h00,
  parameter logic [8*NIO-1:0]  IO_BASE     = {8'h10, 8'h00},
  parameter logic [8*NIO-1:0]  IO_MASK     = {8'hFE, 8'hFE},
  parameter int                BOOT_EN     = 1,
  parameter logic [15:0]       BOOT_VECTOR = 16'hFD00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_odata,
  input  logic              cpu_sync,
  input  logic              cpu_rd,
  input  logic              cpu_wr_n,
  output logic [7:0]        cpu_idata,
  output logic              cpu_ready,
  output logic [7:0]        status,
  output logic              boot_active,
  output logic [NREG-1:0]   mem_rd,
  output logic [NREG-1:0]   mem_we,
  input  logic [8*NREG-1:0] mem_data,
  output logic [NIO-1:0]    io_rd,
  output logic [NIO-1:0]    io_we,
  input  logic [8*NIO-1:0]  io_data,
  output logic              fault,
  output logic [15:0]       fault_addr
);

  bus_state_e      state;
  logic [1:0]      wait_cnt;
  logic [NREG-1:0] mem_sel;
  logic [NIO-1:0]  io_sel;
  logic            mem_any, io_any;
  logic [2:0]      mem_idx, io_idx;
  logic [1:0]      acc_wait;
  logic [7:0]      boot_byte;

  logic is_io_rd, is_io_wr, is_io, wr_act, access;
  assign is_io_rd = status[STATUS_INP];
  assign is_io_wr = status[STATUS_OUT];
  assign is_io    = is_io_rd | is_io_wr;
  assign wr_act   = ~cpu_wr_n;
  assign access   = cpu_rd | wr_act;

  // Descending scan so the lowest matching index is the one left standing.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mem_sel = '0;
    mem_any = 1'b0;
    mem_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (field_match(cpu_addr[15:8], REG_BASE[8*i +: 8], REG_MASK[8*i +: 8])) begin
        mem_sel    = '0;
        mem_sel[i] = 1'b1;
        mem_any    = 1'b1;
        mem_idx    = 3'(i);
      end
    end
    io_sel = '0;
    io_any = 1'b0;
    io_idx = '0;
    for (int i = NIO - 1; i >= 0; i--) begin
      if (field_match(cpu_addr[7:0], IO_BASE[8*i +: 8], IO_MASK[8*i +: 8])) begin
        io_sel    = '0;
        io_sel[i] = 1'b1;
        io_any    = 1'b1;
        io_idx    = 3'(i);
      end
    end
  end

  // The boot overlay owns every read while active, so no slave sees a read strobe.
  assign mem_rd = (cpu_rd & ~boot_active & ~is_io & ~reset) ? mem_sel : '0;
  assign mem_we = (wr_act & ~is_io & ~reset) ? (mem_sel & ~REG_RO) : '0;
  assign io_rd  = (cpu_rd & ~boot_active & is_io_rd & ~reset) ? io_sel : '0;
  assign io_we  = (wr_act & is_io_wr & ~reset) ? io_sel : '0;

  always_comb begin
    cpu_idata = UNMAPPED_DATA;
    if (cpu_rd) begin
      if (boot_active)           cpu_idata = boot_byte;
      else if (is_io) begin
        if (is_io_rd && io_any)  cpu_idata = io_data[8*io_idx +: 8];
      end else if (mem_any)      cpu_idata = mem_data[8*mem_idx +: 8];
    end
  end

  assign acc_wait = (!is_io && mem_any) ? REG_WAIT[2*mem_idx +: 2] : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) status <= 8'h00;
    else if (cpu_sync) status <= cpu_odata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      cpu_ready <= 1'b1;
    end else if (cpu_ce) begin
      case (state)
        IDLE: if (access) begin
          if (acc_wait != 2'd0) begin
            wait_cnt  <= acc_wait;
            state     <= WAIT;
            cpu_ready <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        WAIT: if (wait_cnt == 2'd1) begin
          wait_cnt  <= 2'd0;
          state     <= DONE;
          cpu_ready <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 2'd1;
        end
        DONE: if (!access) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  s100_boot_seq #(
    .BOOT_EN    (BOOT_EN),
    .BOOT_VECTOR(BOOT_VECTOR)
  ) u_boot (
    .clk        (clk),
    .reset      (reset),
    .rd_done    (cpu_ce & cpu_rd & cpu_ready),
    .boot_active(boot_active),
    .boot_byte  (boot_byte)
  );

`ifdef S100_BUS_FAULT_EN
  logic bad_access;
  assign bad_access = (is_io ? ~io_any : ~mem_any)
                    | (wr_act & ~is_io & mem_any & REG_RO[mem_idx]);

  // Flagged only on the IDLE cycle that starts the access, giving a single pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= 16'h0000;
    end else begin
      fault <= cpu_ce & (state == IDLE) & access & bad_access;
      if (cpu_ce && state == IDLE && access && bad_access) fault_addr <= cpu_addr;
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_addr = 16'h0000;
`endif

endmodule
